// File: rtl/hilo_mdu_pkg.sv
// Shared opcodes, division FSM encoding and helpers for the HI/LO multiply-divide unit.
package hilo_mdu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OP_W      = 5;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

    localparam logic [OP_W-1:0] MULT_CONTROL  = 5'b11000;
    localparam logic [OP_W-1:0] MULTU_CONTROL = 5'b11001;
    localparam logic [OP_W-1:0] DIV_CONTROL   = 5'b11010;
    localparam logic [OP_W-1:0] DIVU_CONTROL  = 5'b11011;
    localparam logic [OP_W-1:0] MTHI_CONTROL  = 5'b11100;
    localparam logic [OP_W-1:0] MTLO_CONTROL  = 5'b11101;
    localparam logic [OP_W-1:0] MFHI_CONTROL  = 5'b11110;
    localparam logic [OP_W-1:0] MFLO_CONTROL  = 5'b11111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/hilo_mdu_div_step.sv
// One radix-2 restoring division step: shift remainder, trial subtract, emit quotient bit.
module div_step
    import hilo_mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem_c,
    output logic [XLEN-1:0] next_quo_c
);

    logic [XLEN:0] rem_sh;
    logic          ge;

    always_comb begin
        rem_sh     = {rem, quo[XLEN-1]};
        ge         = rem_sh >= (XLEN+1)'(divisor);
        next_rem_c = ge ? XLEN'(rem_sh - (XLEN+1)'(divisor)) : rem_sh[XLEN-1:0];
        next_quo_c = {quo[XLEN-2:0], ge};
    end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO register file with single-cycle multiply and a 32-step iterative divider.
module hilo_mdu
    import hilo_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [OP_W-1:0] alucontrol_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            stall_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic [XLEN-1:0] result_o
);

    div_state_t       state;
    hilo_t            hilo;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  dvs;
    logic [XLEN-1:0]  dvd_raw;
    logic             q_neg;
    logic             r_neg;
    logic             div_zero;

    logic             accept;
    logic             is_div;
    logic             a_neg;
    logic             b_neg;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [XLEN-1:0]  step_rem;
    logic [XLEN-1:0]  step_quo;
    hilo_t            div_res;

    // Accept decode and pipeline hold; a flush in BUSY releases the stall immediately.
    always_comb begin
        is_div  = (alucontrol_i == DIV_CONTROL) || (alucontrol_i == DIVU_CONTROL);
        accept  = valid_i && !flush_i && (state == IDLE);
        a_neg   = (alucontrol_i == DIV_CONTROL) && a_i[XLEN-1];
        b_neg   = (alucontrol_i == DIV_CONTROL) && b_i[XLEN-1];
        stall_o = (accept && is_div) || ((state == BUSY) && !flush_i);
    end

    always_comb begin
        result_o = '0;
        if (alucontrol_i == MFHI_CONTROL) begin
            result_o = hilo.hi;
        end else if (alucontrol_i == MFLO_CONTROL) begin
            result_o = hilo.lo;
        end
    end

    assign prod_s = 64'($signed(a_i)) * 64'($signed(b_i));
    assign prod_u = 64'(a_i) * 64'(b_i);

    // Divide-by-zero bypasses the sign fix-up and reports the original dividend.
    always_comb begin
        div_res.hi = cond_neg(rem, r_neg);
        div_res.lo = cond_neg(quo, q_neg);
        if (div_zero) begin
            div_res.hi = dvd_raw;
            div_res.lo = '1;
        end
    end

    div_step u_div_step (
        .rem        (rem),
        .quo        (quo),
        .divisor    (dvs),
        .next_rem_c (step_rem),
        .next_quo_c (step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hilo     <= '0;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dvd_raw  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        case (alucontrol_i)
                            MULT_CONTROL:  hilo    <= prod_s;
                            MULTU_CONTROL: hilo    <= prod_u;
                            MTHI_CONTROL:  hilo.hi <= a_i;
                            MTLO_CONTROL:  hilo.lo <= a_i;
                            DIV_CONTROL, DIVU_CONTROL: begin
                                state    <= BUSY;
                                cnt      <= '0;
                                rem      <= '0;
                                quo      <= cond_neg(a_i, a_neg);
                                dvs      <= cond_neg(b_i, b_neg);
                                q_neg    <= a_neg ^ b_neg;
                                r_neg    <= a_neg;
                                div_zero <= (b_i == '0);
                                dvd_raw  <= a_i;
                            end
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DIV_ITERS - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!flush_i) begin
                        hilo <= div_res;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hi_o = hilo.hi;
    assign lo_o = hilo.lo;

endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have exactly one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 SHALL expose ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  execute-stage instruction valid
- flush_i  in  1  kill the current instruction or abort division
- alucontrol_i  in  5  operation code from the ALU decoder
- a_i  in  32  rs operand / dividend / MTHI-MTLO source
- b_i  in  32  rt operand / divisor
- stall_o  out  1  pipeline hold request
- hi_o  out  32  architectural HI register
- lo_o  out  32  architectural LO register
- result_o  out  32  MFHI/MFLO read data

Function
REQ-003 SHALL act on MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL, MTHI_CONTROL, MTLO_CONTROL, MFHI_CONTROL and MFLO_CONTROL only. All other codes are no-ops.
REQ-004 An operation SHALL be accepted only when valid_i=1, flush_i=0 and FSM=IDLE.
REQ-005 MULT/MULTU SHALL write {HI,LO} at the accepting edge with the full 64-bit product, signed or unsigned respectively, without asserting stall_o.
REQ-006 MTHI/MTLO SHALL write a_i to HI/LO respectively at the accepting edge; the other register holds.
REQ-007 result_o SHALL be combinational: hi_o for MFHI_CONTROL, lo_o for MFLO_CONTROL, otherwise 0.
REQ-008 The division FSM SHALL have three states, IDLE, BUSY and DONE:
- IDLE->BUSY on an accepted DIV/DIVU; latch operand magnitudes and sign flags; counter=0.
- BUSY: one radix-2 restoring step per cycle; ->DONE when counter=31.
- DONE: write HI/LO at the edge; ->IDLE.
REQ-009 stall_o SHALL be 1 combinationally in the accepting cycle and in every BUSY cycle, and 0 in IDLE (otherwise) and in DONE. Result: exactly 33 stall cycles; HI/LO visible 34 cycles after acceptance.
REQ-010 In DONE the still-present DIV instruction SHALL NOT be re-accepted.
REQ-011 Signed division sign rules:
- quotient negative iff operand signs differ
- remainder takes the dividend's sign
- -2^31 / -1 yields LO=0x80000000, HI=0
REQ-012 Divide by zero SHALL still take the full 33 stall cycles and then write HI=a_i (as latched) and LO=0xFFFFFFFF, signed or unsigned.
REQ-013 flush_i=1 in BUSY or DONE SHALL abort the division: next state IDLE, HI/LO unchanged, stall_o=0 in that cycle.
REQ-014 flush_i=1 in IDLE SHALL suppress all writes that cycle.
REQ-015 When DONE's write and an accepted op would coincide, DONE SHALL win; accept is structurally impossible in DONE per REQ-004.

Reset
REQ-016 rst=1 at a rising edge SHALL set HI=0, LO=0, FSM=IDLE, counter=0 and clear all division working registers.
REQ-017 Reset SHALL take priority over flush_i and valid_i. Reset mid-division discards it; stall_o=0 the following cycle.

Structure
REQ-018 The *_CONTROL operation codes SHALL come from the shared defines2.vh package; FSM state encodings and DIV_ITERS=32 SHALL be local constants promoted to that package.
REQ-019 The one-bit restoring step (shift remainder, trial subtract, quotient bit) SHALL be a single combinational sub-module div_step. The FSM, counter and HI/LO registers stay in hilo_mdu.

Verification
REQ-020 MULT a=0xFFFFFFFE (-2), b=3 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, stall_o never 1; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-021 DIV a=-7 (0xFFFFFFF9), b=2 held valid -> stall_o=1 for exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-022 DIVU a=0x12345678, b=0 -> 33 stall cycles, then HI=0x12345678, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-023 DIV started, flush_i pulsed in BUSY cycle 10 -> stall_o=0 that cycle, FSM IDLE, HI/LO equal pre-division values; a following MTLO 0x55 writes LO=0x55 next edge.
REQ-024 DIV started, rst asserted in BUSY cycle 5 -> HI=LO=0, stall_o=0 next cycle; MTHI with flush_i=1 -> HI unchanged; MFHI after MTHI 0xA5A5A5A5 -> result_o=0xA5A5A5A5.
